// File: rtl/ac_pkg.sv
// Shared types and constants for the access-control stream bridge.
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_DIM_WIDTH  = 16;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ac_stream_bridge_if.sv
// Handshake bundle of the bridge: AXI-Stream in, upsp read/write, AXI-Stream out.
interface ac_stream_bridge_if
    import ac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;

    logic                  upsp_ac_rd;
    logic                  ac_upsp_rvalid;
    logic [DATA_WIDTH-1:0] ac_upsp_rdata;

    logic                  upsp_ac_wrt;
    logic                  ac_upsp_wready;
    logic [DATA_WIDTH-1:0] upsp_ac_wdata;

    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    // Environment side: stream source, upsp core and stream sink.
    modport master (
        output s_axis_tvalid, s_axis_tdata,
        input  s_axis_tready,
        output upsp_ac_rd,
        input  ac_upsp_rvalid, ac_upsp_rdata,
        output upsp_ac_wrt, upsp_ac_wdata,
        input  ac_upsp_wready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );

    // Bridge side.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata,
        output s_axis_tready,
        input  upsp_ac_rd,
        output ac_upsp_rvalid, ac_upsp_rdata,
        input  upsp_ac_wrt, upsp_ac_wdata,
        output ac_upsp_wready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

endinterface

// File: rtl/ac_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible the cycle after a push.
module ac_sync_fifo
    import ac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH = 16,
    localparam int PW   = ptr_width(DEPTH),
    localparam int AW   = PW - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head is forced to zero when empty so stale storage never reaches an output.
    assign dout = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ac_stream_bridge.sv
// Access-control bridge: buffers pixels into upsp, buffers results out, frames the output stream.
module ac_stream_bridge
    import ac_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int IN_FIFO_DEPTH  = 16,
    parameter int OUT_FIFO_DEPTH = 16,
    parameter int DIM_WIDTH      = DEFAULT_DIM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 irq_clr,
    input  logic [DIM_WIDTH-1:0] cfg_out_width,
    input  logic [DIM_WIDTH-1:0] cfg_out_height,
    output logic                 busy,
    output logic                 interrupt_updone,
    ac_stream_bridge_if.slave    bus
);

    localparam int IN_PW  = ptr_width(IN_FIFO_DEPTH);
    localparam int OUT_PW = ptr_width(OUT_FIFO_DEPTH);

    state_t               state_q, state_d;
    logic [DIM_WIDTH-1:0] width_q, width_d;
    logic [DIM_WIDTH-1:0] height_q, height_d;
    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic                 irq_q, irq_d;

    logic              run;
    logic              in_push, in_pop, in_flush, in_full, in_empty;
    logic              out_push, out_pop, out_full, out_empty;
    logic              col_last, row_last;
    logic [IN_PW-1:0]  unused_in_count;
    logic [OUT_PW-1:0] unused_out_count;

    assign run  = (state_q == RUN);
    assign busy = run;
    assign interrupt_updone = irq_q;

    assign bus.s_axis_tready  = run & ~in_full;
    assign bus.ac_upsp_rvalid = run & ~in_empty;
    assign bus.ac_upsp_wready = run & ~out_full;
    assign bus.m_axis_tvalid  = ~out_empty;

    assign in_push  = bus.s_axis_tvalid & bus.s_axis_tready;
    assign in_pop   = bus.upsp_ac_rd & bus.ac_upsp_rvalid;
    assign out_push = bus.upsp_ac_wrt & bus.ac_upsp_wready;
    assign out_pop  = bus.m_axis_tvalid & bus.m_axis_tready;

    assign col_last = (col_q == width_q - DIM_WIDTH'(1));
    assign row_last = (row_q == height_q - DIM_WIDTH'(1));

    assign bus.m_axis_tlast = bus.m_axis_tvalid & col_last;
    assign bus.m_axis_tuser = bus.m_axis_tvalid & (col_q == '0) & (row_q == '0);

    ac_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_FIFO_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_push),
        .pop   (in_pop),
        .flush (in_flush),
        .din   (bus.s_axis_tdata),
        .dout  (bus.ac_upsp_rdata),
        .full  (in_full),
        .empty (in_empty),
        .count (unused_in_count)
    );

    // The output side is only ever cleared by reset so results already produced still drain.
    ac_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_FIFO_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (out_push),
        .pop   (out_pop),
        .flush (1'b0),
        .din   (bus.upsp_ac_wdata),
        .dout  (bus.m_axis_tdata),
        .full  (out_full),
        .empty (out_empty),
        .count (unused_out_count)
    );

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        irq_d    = irq_q;
        in_flush = 1'b0;

        if (out_pop) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + DIM_WIDTH'(1);
            end else begin
                col_d = col_q + DIM_WIDTH'(1);
            end
        end

        if (irq_clr) irq_d = 1'b0;

        // Later assignments win: an accepted start resets counters, DONE's set beats irq_clr.
        case (state_q)
            IDLE: begin
                if (start && (cfg_out_width != '0) && (cfg_out_height != '0)) begin
                    width_d  = cfg_out_width;
                    height_d = cfg_out_height;
                    col_d    = '0;
                    row_d    = '0;
                    irq_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (out_pop && col_last && row_last) state_d = DONE;
            end
            DONE: begin
                irq_d    = 1'b1;
                in_flush = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            col_q    <= col_d;
            row_q    <= row_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_ac_stream_bridge.sv
// Randomized scoreboard bench for ac_stream_bridge with a loopback upsp (result = pixel + 1).
module tb_ac_stream_bridge;

    localparam int DW   = 24;
    localparam int DIMW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            irq_clr = 1'b0;
    logic [DIMW-1:0] cfg_w = '0;
    logic [DIMW-1:0] cfg_h = '0;
    logic            busy;
    logic            irq;

    ac_stream_bridge_if #(.DATA_WIDTH(DW)) bus ();

    ac_stream_bridge #(
        .DATA_WIDTH     (DW),
        .IN_FIFO_DEPTH  (16),
        .OUT_FIFO_DEPTH (16),
        .DIM_WIDTH      (DIMW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .irq_clr          (irq_clr),
        .cfg_out_width    (cfg_w),
        .cfg_out_height   (cfg_h),
        .busy             (busy),
        .interrupt_updone (irq),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          fin;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] in_q[$];
    int            passed = 0;
    int            total = 0;
    int            beats = 0;
    int            fin_cnt = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit            lb_rand = 1'b0;
    bit            in_rand = 1'b0;
    logic          lb_en = 1'b1;
    logic          acc;

    // Loopback upsp: only reads a pixel when it can hand the result straight back.
    assign bus.upsp_ac_rd    = lb_en & bus.ac_upsp_wready;
    assign bus.upsp_ac_wrt   = lb_en & bus.ac_upsp_rvalid;
    assign bus.upsp_ac_wdata = bus.ac_upsp_rdata + 24'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) acc <= bus.s_axis_tvalid & bus.s_axis_tready;

    // Source, sink-ready and upsp-stall drivers, all updated just after the clock edge.
    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;
        forever begin
            tick();
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            if (!(bus.s_axis_tvalid && !acc && in_q.size() > 0))
                bus.s_axis_tvalid = (in_q.size() > 0) && (!in_rand || $urandom_range(0, 3) != 0);
            bus.s_axis_tdata  = (in_q.size() > 0) ? in_q[0] : '0;
            case (rdy_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
                default: bus.m_axis_tready = 1'b0;
            endcase
            lb_en = lb_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every output handshake is compared against the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got data 0x%06h, expected no beat", bus.m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat %0d data=0x%06h last=%0b user=%0b", beats,
                             bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser);
                    check("beat{data,last,user}",
                          {38'd0, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                          {38'd0, e.data, e.last, e.user});
                    if (e.fin) fin_cnt++;
                end
            end
        end
    end

    function automatic logic [63:0] all_outputs();
        return {8'd0, busy, irq, bus.s_axis_tready, bus.ac_upsp_rvalid, bus.ac_upsp_rdata,
                bus.ac_upsp_wready, bus.m_axis_tvalid, bus.m_axis_tdata,
                bus.m_axis_tlast, bus.m_axis_tuser};
    endfunction

    task automatic start_frame(input int w, input int h);
        cfg_w = DIMW'(w);
        cfg_h = DIMW'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reference model: beat i of a w-wide frame is pixel i + 1, tlast at i%w==w-1, tuser at i==0.
    task automatic load_frame(input int w, input int h, input bit rnd);
        beat_t         e;
        logic [DW-1:0] d;
        for (int i = 0; i < w * h; i++) begin
            d = rnd ? DW'($urandom) : DW'(i + 1);
            in_q.push_back(d);
            e.data = d + 24'd1;
            e.last = (i % w == w - 1);
            e.user = (i == 0);
            e.fin  = (i == w * h - 1);
            exp_q.push_back(e);
        end
    endtask

    // The final beat moves the FSM into DONE; the interrupt shows one cycle later.
    task automatic wait_done(input string name, input bit clr_at_done);
        int f0 = fin_cnt;
        int n = 0;
        while (fin_cnt == f0 && n < 3000) begin
            tick();
            n++;
        end
        if (fin_cnt == f0) begin
            total++;
            $display("FAIL %s_timeout: got no final beat, expected one within 3000 cycles", name);
        end else begin
            check({name, "_done_cycle{busy,irq}"}, {62'd0, busy, irq}, 64'd0);
            if (clr_at_done) irq_clr = 1'b1;
            tick();
            irq_clr = 1'b0;
            check({name, "_irq_set"}, {63'd0, irq}, 64'd1);
            check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic run_frame(input string name, input int w, input int h,
                             input bit rnd, input bit clr_at_done);
        start_frame(w, h);
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        load_frame(w, h, rnd);
        wait_done(name, clr_at_done);
    endtask

    initial begin
        int b0;
        int n;

        repeat (3) tick();
        check("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed 4x2 frame: pixels 1..8 come back as 2..9.
        run_frame("frame4x2", 4, 2, 1'b0, 1'b0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr", {63'd0, irq}, 64'd0);

        // Starts with a zero dimension are ignored.
        start_frame(0, 3);
        check("zero_width{busy,tready}", {62'd0, busy, bus.s_axis_tready}, 64'd0);
        start_frame(3, 0);
        check("zero_height{busy,tready}", {62'd0, busy, bus.s_axis_tready}, 64'd0);

        // A start during RUN (with new live cfg values) must not disturb framing.
        start_frame(2, 3);
        load_frame(2, 3, 1'b1);
        tick();
        cfg_w = DIMW'(5);
        cfg_h = DIMW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored_busy", {63'd0, busy}, 64'd1);
        wait_done("restart_ignored", 1'b0);

        // Random geometry, random backpressure and upsp stalls.
        rdy_mode = 1;
        lb_rand  = 1'b1;
        in_rand  = 1'b1;
        for (int k = 0; k < 5; k++)
            run_frame("random", $urandom_range(1, 5), $urandom_range(1, 4), 1'b1, 1'b0);
        run_frame("width1", 1, 3, 1'b1, 1'b0);
        run_frame("irq_clr_at_done", 3, 2, 1'b1, 1'b1);
        check("irq_held_after_clr_at_done", {63'd0, irq}, 64'd1);

        // Backpressure: 20 pixels, output FIFO fills to 16 while 4 wait upstream.
        rdy_mode = 2;
        lb_rand  = 1'b0;
        in_rand  = 1'b0;
        start_frame(4, 5);
        load_frame(4, 5, 1'b1);
        repeat (40) tick();
        check("bp_out_full_wready", {63'd0, bus.ac_upsp_wready}, 64'd0);
        check("bp_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd1);
        check("bp_pending_rvalid", {63'd0, bus.ac_upsp_rvalid}, 64'd1);
        check("bp_all_inputs_accepted", 64'(in_q.size()), 64'd0);
        rdy_mode = 0;
        wait_done("backpressure", 1'b0);

        // Asynchronous reset after 5 of 8 beats, then a clean frame.
        start_frame(4, 2);
        load_frame(4, 2, 1'b1);
        b0 = beats;
        n  = 0;
        while (beats - b0 < 5 && n < 500) begin
            tick();
            n++;
        end
        check("midframe_beats_before_reset", 64'(beats - b0 >= 5), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        in_q.delete();
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", all_outputs(), 64'd0);
        run_frame("after_reset", 4, 2, 1'b0, 1'b0);

        repeat (5) tick();
        check("no_stray_beats", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ac_stream_bridge.md
Name: ac_stream_bridge

Overview:
Parametrised access-control datapath between the AXI-Stream ports and the up-sampling core (upsp).
- Input pixels from the AXI-Stream slave are buffered in a FIFO and served to upsp on its read handshake.
- upsp results are buffered in a second FIFO and emitted on the AXI-Stream master with line (tlast) and frame (tuser) framing.
- Frame geometry is runtime-configured. Frame completion raises interrupt_updone.

Parameters:
DATA_WIDTH, 24, pixel width on both AXI-Stream buses and both upsp data buses.
IN_FIFO_DEPTH, 16, input FIFO entries; power of two, at least 2.
OUT_FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.
DIM_WIDTH, 16, width of the line-length and line-count configuration fields.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from the register file (UPSTR write); starts a frame
irq_clr  in  1  one-cycle pulse; clears interrupt_updone
cfg_out_width  in  DIM_WIDTH  output pixels per line
cfg_out_height  in  DIM_WIDTH  output lines per frame
busy  out  1  high in RUN
s_axis_tvalid  in  1  input stream valid
s_axis_tready  out  1  input stream ready
s_axis_tdata  in  DATA_WIDTH  input pixel
upsp_ac_rd  in  1  upsp requests a pixel
ac_upsp_rvalid  out  1  pixel available to upsp
ac_upsp_rdata  out  DATA_WIDTH  pixel to upsp
upsp_ac_wrt  in  1  upsp offers a result
ac_upsp_wready  out  1  result accepted
upsp_ac_wdata  in  DATA_WIDTH  result pixel
m_axis_tvalid  out  1  output stream valid
m_axis_tready  in  1  output stream ready
m_axis_tdata  out  DATA_WIDTH  output pixel
m_axis_tlast  out  1  last pixel of a line
m_axis_tuser  out  1  first pixel of a frame
interrupt_updone  out  1  frame-done interrupt, level

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset: all outputs are 0, both FIFOs are empty, state is IDLE, and all counters are 0. Reset mid-frame discards all buffered data with no partial output.
- States:
  - IDLE: on start with cfg_out_width!=0 and cfg_out_height!=0, latch both fields, zero the column and row counters, clear interrupt_updone, and go to RUN. A start with either field 0 is ignored.
  - RUN: busy=1. start is ignored. Go to DONE on the master handshake where col==width-1 and row==height-1.
  - DONE: one cycle. Set interrupt_updone, flush the input FIFO (leftover input is discarded), and return to IDLE.
- Handshakes:
  - s_axis_tready = RUN and input FIFO not full. A push occurs on tvalid & tready. Input in IDLE or DONE is stalled, not dropped.
  - ac_upsp_rvalid = RUN and input FIFO not empty. ac_upsp_rdata is the FIFO head (first-word fall-through). A pop occurs on upsp_ac_rd & ac_upsp_rvalid.
  - ac_upsp_wready = RUN and output FIFO not full. A push occurs on upsp_ac_wrt & ac_upsp_wready.
  - m_axis_tvalid = output FIFO not empty, in any state. The output FIFO is never flushed except by reset. m_axis_tdata is the head. A pop occurs on tvalid & tready.
  - All outputs are combinational from registered FIFO state; there is no path from any ready input to a valid output.
- Latency: a pixel pushed on cycle N is visible on the consumer side on cycle N+1.
- Simultaneous push and pop on the same FIFO are allowed. The count is unchanged, including when full (pop frees the slot, push refills it) and when at 1 entry.
- Framing:
  - The col counter advances on each master handshake. At width-1 it wraps to 0 and row increments.
  - m_axis_tlast = (col==width-1) while tvalid.
  - m_axis_tuser = (col==0 and row==0) while tvalid.
  - width==1 gives tlast on every beat.
- Arithmetic: counters are DIM_WIDTH bits and compare only against the latched values, never against the live cfg_* ports.
- interrupt_updone is set in DONE and cleared by irq_clr or by the next accepted start. irq_clr and set in the same cycle: set wins.

Decomposition:
- Shared package ac_pkg:
  - state enum {IDLE, RUN, DONE}
  - default DATA_WIDTH and DIM_WIDTH constants
  - function clog2-based pointer width
- Sub-module ac_sync_fifo: first-word-fall-through, parameters WIDTH and DEPTH. Ports: push, pop, flush, din, dout, full, empty, count. Pointers are one bit wider than the address for the full/empty test. Instantiated twice.

Test Plan:
- Frame 4x2: 8 input pixels 0x000001..0x000008, loopback upsp (rd always high, result=data+1) -> 8 output beats 0x000002..0x000009. tuser on beat 0 only, tlast on beats 3 and 7, interrupt_updone rises 1 cycle after beat 7.
- Backpressure: m_axis_tready low for 40 cycles in a 4x4 frame with depth 16 -> output FIFO holds 16 entries, ac_upsp_wready=0, no beat lost, order preserved after release.
- Full-boundary simultaneous push and pop on the output FIFO at count 16 -> count stays 16, data order intact.
- start with cfg_out_width=0 -> stays IDLE, busy=0, s_axis_tready=0. A second start during RUN does not restart the counters.
- rst_n pulsed low mid-frame after 5 of 8 beats -> all outputs are 0 immediately (asynchronous). A new 4x2 frame then completes correctly with tuser on its first beat.
- interrupt_updone asserted, then irq_clr -> 0 next cycle. irq_clr coincident with DONE -> stays 1.
